clock_rate_gen: RTL and testbench
=================================

// Module: clock_rate_gen
// PURPOSE
// - Parametrised successor to the stopwatch clock divider. Produces a one-cycle tick enable at a
//   selectable rate (normal / speed-up / slow-down), plus a companion square wave for display.
// - Everything runs in the single clk domain: S0/S1/M0/M1 counters qualify on tick. No derived clocks.
// - Mode changes are glitch-free: they take effect only at a tick boundary. Adds run/pause and phase clear.
// PARAMETERS
// - CLK_HZ        50_000_000  input clock frequency, Hz
// - BASE_HZ       1           normal-mode tick rate, Hz; P_NORM = CLK_HZ/BASE_HZ cycles
// - SPEED_FACTOR  2           speed-up rate multiplier; P_FAST = P_NORM/SPEED_FACTOR
// - SLOW_FACTOR   2           slow-down rate divisor; P_SLOW = P_NORM*SLOW_FACTOR
// PORTS
// - clk        in   1  system clock
// - rst_n      in   1  synchronous reset, active-low
// - speedup    in   1  mode select bit 1
// - slowdown   in   1  mode select bit 0
// - run        in   1  1 = count; 0 = freeze counter and phase (pause)
// - clear      in   1  restart the current period from zero; no tick is produced
// - tick       out  1  one-cycle pulse, once per selected period
// - sq_out     out  1  square wave: high for the first floor(P/2) cycles of each period
// - mode_q     out  2  mode currently in force (mode_e)
// BEHAVIOUR
// - The design has one clock, clk. Reset is synchronous and active-low (rst_n).
// - Mode map, sel = {speedup,slowdown}:
//   - 00 = NORM (P_NORM)
//   - 01 = SLOW (P_SLOW)
//   - 10 = FAST (P_FAST)
//   - 11 = NORM (P_NORM); both buttons held means normal rate
// - Reset (rst_n=0 at a clk edge) sets: cnt=0, tick=0, sq_out=1, mode_q=NORM, pending=NORM.
// - cnt is an up-counter of width CW = $clog2(P_SLOW). Active period P = period(mode_q).
// - Each cycle with run=1 and clear=0:
//   - if cnt == P-1: cnt<=0, tick<=1, mode_q<=pending
//   - else: cnt<=cnt+1, tick<=0
// - Tick timing: tick is registered and asserts the cycle after cnt==P-1.
//   - First tick after reset release comes P cycles later; thereafter exactly every P cycles.
// - pending is sampled from sel every cycle, including while paused.
//   - The new mode applies only when the period in progress completes, so no short or long
//     partial period follows a mode change.
// - run=0: cnt, mode_q and sq_out hold; tick<=0. On resume, counting continues from the held cnt.
// - clear=1 (run is ignored): cnt<=0, tick<=0, mode_q<=pending (mode applied at once). Clear takes
//   priority over terminal count if both fall in the same cycle.
// - sq_out is registered: sq_out <= (next cnt < P/2), with P the period of the next mode_q.
//   Odd P gives a low phase one cycle longer than the high phase.
// - Elaboration checks: $error on any of
//   - P_FAST < 2
//   - P_NORM % SPEED_FACTOR != 0
//   - CLK_HZ % BASE_HZ != 0
//   - SPEED_FACTOR < 1 or SLOW_FACTOR < 1
// - Precedence, high to low: rst_n=0 > clear > run=0 > normal counting.
// STRUCTURE
// - stopwatch_pkg holds:
//   - typedef enum logic [1:0] mode_e {NORM=2'b00, SLOW=2'b01, FAST=2'b10}
//   - function period_of(mode_e, P_NORM, SPEED_FACTOR, SLOW_FACTOR)
// - Sub-module tick_counter #(CW): loadable up-counter with terminal-count compare and sync clear.
//   The top level owns the mode register, the period mux and sq_out.
// TESTING (bench params CLK_HZ=20, BASE_HZ=1, SPEED=2, SLOW=2 -> P_NORM=20, P_FAST=10, P_SLOW=40)
// - Reset, sel=00, run=1:
//   - tick at cycles 20, 40, 60 after rst_n release
//   - sq_out high for 10 cycles, low for 10
//   - mode_q=NORM throughout
// - sel 00->10 at cycle 25: the period in progress still ends at 40; mode_q=FAST from then;
//   next ticks at 50 and 60.
// - sel=01: ticks every 40 cycles. Toggle sel=10 for 3 cycles mid-period, then back to 01:
//   period unchanged; mode_q stays SLOW.
// - run=0 for 7 cycles starting at cnt=5 in NORM:
//   - no tick; cnt and sq_out hold
//   - next tick arrives 27 cycles after the previous one
// - clear at cnt=15 with sel=10:
//   - no tick; mode_q=FAST immediately
//   - tick 10 cycles later
//   - clear coincident with cnt==P-1: no tick
// - rst_n=0 mid-period in SLOW:
//   - next edge gives cnt=0, tick=0, sq_out=1, mode_q=NORM
//   - after release the first tick follows 20 cycles later (sel=00)

Source files
------------

// File: rtl/clock_rate_gen_pkg.sv
// Shared types and helpers for the selectable-rate tick generator:
// rate modes, the period lookup and the speed/slow button decode.
package clock_rate_gen_pkg;

  typedef enum logic [1:0] {
    NORM = 2'b00,
    SLOW = 2'b01,
    FAST = 2'b10
  } mode_e;

  // Period in clk cycles of one tick interval for a given mode.
  function automatic int period_of(input mode_e mode, input int p_norm,
                                   input int speed_factor, input int slow_factor);
    case (mode)
      SLOW:    return p_norm * slow_factor;
      FAST:    return p_norm / speed_factor;
      default: return p_norm;
    endcase
  endfunction

  // Both buttons held together falls back to the normal rate.
  function automatic mode_e sel_to_mode(input logic speedup, input logic slowdown);
    case ({speedup, slowdown})
      2'b01:   return SLOW;
      2'b10:   return FAST;
      default: return NORM;
    endcase
  endfunction

endpackage

// File: rtl/clock_rate_gen_tick_counter.sv
// Period counter: counts up while enabled, wraps at a runtime terminal value,
// and can be forced back to zero by a synchronous clear.
module tick_counter #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] last,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_next,
  output logic          tc
);

  assign tc = (cnt == last);

  // Clear outranks enable so a paused counter can still be restarted.
  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = tc ? '0 : cnt + CW'(1);
    end
  end

  // NOTE: registers take <= so every flop samples pre-edge values; '=' here
  // would race with other clocked blocks reading cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/clock_rate_gen.sv
// Single-clock tick enable generator with normal / fast / slow rates, a display
// square wave, run/pause and phase clear. Rate changes land only on tick boundaries.
module clock_rate_gen
  import clock_rate_gen_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BASE_HZ      = 1,
  parameter int SPEED_FACTOR = 2,
  parameter int SLOW_FACTOR  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       speedup,
  input  logic       slowdown,
  input  logic       run,
  input  logic       clear,
  output logic       tick,
  output logic       sq_out,
  output logic [1:0] mode_q
);

  localparam int P_NORM = CLK_HZ / BASE_HZ;
  localparam int P_FAST = P_NORM / SPEED_FACTOR;
  localparam int P_SLOW = P_NORM * SLOW_FACTOR;
  localparam int CW     = $clog2(P_SLOW);

  if (SPEED_FACTOR < 1 || SLOW_FACTOR < 1) begin : g_bad_factor
    $error("clock_rate_gen: SPEED_FACTOR and SLOW_FACTOR must be >= 1");
  end
  if (CLK_HZ % BASE_HZ != 0) begin : g_bad_base
    $error("clock_rate_gen: CLK_HZ must be a multiple of BASE_HZ");
  end
  if (P_NORM % SPEED_FACTOR != 0) begin : g_bad_speed
    $error("clock_rate_gen: P_NORM must be a multiple of SPEED_FACTOR");
  end
  if (P_FAST < 2) begin : g_bad_fast
    $error("clock_rate_gen: fast period must be at least 2 cycles");
  end

  mode_e         mode_reg;
  mode_e         pending;
  mode_e         sel_mode;
  mode_e         mode_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] last;
  logic [CW-1:0] half_next;
  logic          tc;
  logic          sq_next;

  assign sel_mode = sel_to_mode(speedup, slowdown);
  assign mode_q   = mode_reg;

  tick_counter #(
    .CW(CW)
  ) u_tick_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (run),
    .clr     (clear),
    .last    (last),
    .cnt     (cnt),
    .cnt_next(cnt_next),
    .tc      (tc)
  );

  // NOTE: each always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mode_next = mode_reg;
    if (clear || (run && tc)) begin
      mode_next = pending;
    end
    last      = CW'(period_of(mode_reg, P_NORM, SPEED_FACTOR, SLOW_FACTOR) - 1);
    half_next = CW'(period_of(mode_next, P_NORM, SPEED_FACTOR, SLOW_FACTOR) / 2);
    sq_next   = (cnt_next < half_next);
  end

  // While paused cnt_next and mode_next equal their current values, so sq_out
  // naturally holds without a separate branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick     <= 1'b0;
      sq_out   <= 1'b1;
      mode_reg <= NORM;
      pending  <= NORM;
    end else begin
      tick     <= !clear && run && tc;
      sq_out   <= sq_next;
      mode_reg <= mode_next;
      pending  <= sel_mode;
    end
  end

endmodule

// File: tb/tb_clock_rate_gen.sv
// Directed bench for clock_rate_gen at CLK_HZ=20: P_NORM=20, P_FAST=10, P_SLOW=40.
module tb_clock_rate_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       speedup;
  logic       slowdown;
  logic       run;
  logic       clear;
  logic       tick;
  logic       sq_out;
  logic [1:0] mode_q;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ticks  = 0;

  typedef struct {
    int         at;
    logic [1:0] sel;
    logic       tick;
    logic       sq;
    logic [1:0] mode;
  } vec_t;

  vec_t vecs[15];

  clock_rate_gen #(
    .CLK_HZ      (20),
    .BASE_HZ     (1),
    .SPEED_FACTOR(2),
    .SLOW_FACTOR (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .speedup (speedup),
    .slowdown(slowdown),
    .run     (run),
    .clear   (clear),
    .tick    (tick),
    .sq_out  (sq_out),
    .mode_q  (mode_q)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tick) ticks++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Steps until tick is seen; n is the number of edges taken.
  task automatic wait_tick(input string name, input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < max);
    if (!tick) begin
      errors++;
      $display("FAIL %s: no tick within %0d cycles", name, max);
    end
  endtask

  initial begin
    int n;
    int t0;

    // at, sel, tick, sq, mode  (sel driven on the edges leading up to 'at')
    vecs[0]  = '{1,  2'b00, 1'b0, 1'b1, 2'b00};
    vecs[1]  = '{9,  2'b00, 1'b0, 1'b1, 2'b00};
    vecs[2]  = '{10, 2'b00, 1'b0, 1'b0, 2'b00};
    vecs[3]  = '{19, 2'b00, 1'b0, 1'b0, 2'b00};
    vecs[4]  = '{20, 2'b00, 1'b1, 1'b1, 2'b00};
    vecs[5]  = '{21, 2'b00, 1'b0, 1'b1, 2'b00};
    vecs[6]  = '{24, 2'b00, 1'b0, 1'b1, 2'b00};
    vecs[7]  = '{25, 2'b10, 1'b0, 1'b1, 2'b00};
    vecs[8]  = '{30, 2'b10, 1'b0, 1'b0, 2'b00};
    vecs[9]  = '{39, 2'b10, 1'b0, 1'b0, 2'b00};
    vecs[10] = '{40, 2'b10, 1'b1, 1'b1, 2'b10};
    vecs[11] = '{44, 2'b10, 1'b0, 1'b1, 2'b10};
    vecs[12] = '{45, 2'b10, 1'b0, 1'b0, 2'b10};
    vecs[13] = '{50, 2'b10, 1'b1, 1'b1, 2'b10};
    vecs[14] = '{60, 2'b10, 1'b1, 1'b1, 2'b10};

    rst_n    = 1'b0;
    speedup  = 1'b0;
    slowdown = 1'b0;
    run      = 1'b1;
    clear    = 1'b0;
    step();
    step();
    check("reset_tick", tick, 1'b0);
    check("reset_sq", sq_out, 1'b1);
    check("reset_mode", mode_q, 2'b00);

    // Normal rate, then a switch to FAST mid-period.
    rst_n = 1'b1;
    cyc   = 0;
    ticks = 0;
    foreach (vecs[i]) begin
      {speedup, slowdown} = vecs[i].sel;
      while (cyc < vecs[i].at) step();
      check($sformatf("vec%0d_tick", i), tick, vecs[i].tick);
      check($sformatf("vec%0d_sq", i), sq_out, vecs[i].sq);
      check($sformatf("vec%0d_mode", i), mode_q, vecs[i].mode);
    end
    check("tick_count_60", ticks, 4);

    // SLOW with a short FAST glitch on the buttons mid-period.
    {speedup, slowdown} = 2'b00;
    do_reset();
    {speedup, slowdown} = 2'b01;
    wait_tick("slow_first", 100, n);
    check("slow_first_gap", n, 20);
    check("slow_mode_on", mode_q, 2'b01);
    wait_tick("slow_second", 100, n);
    check("slow_gap", n, 40);
    repeat (10) step();
    {speedup, slowdown} = 2'b10;
    repeat (3) step();
    check("glitch_mode", mode_q, 2'b01);
    {speedup, slowdown} = 2'b01;
    wait_tick("slow_glitch", 100, n);
    check("slow_glitch_gap", n + 13, 40);
    check("slow_glitch_mode", mode_q, 2'b01);

    // Pause at cnt=5 for 7 cycles, then at cnt=12 for 3 cycles.
    {speedup, slowdown} = 2'b00;
    do_reset();
    wait_tick("pause_first", 100, n);
    repeat (5) step();
    run = 1'b0;
    t0  = ticks;
    repeat (7) step();
    check("pause_no_tick", ticks - t0, 0);
    check("pause_sq_hi", sq_out, 1'b1);
    run = 1'b1;
    wait_tick("pause_resume", 100, n);
    check("pause_gap", n + 12, 27);
    repeat (12) step();
    check("pre_pause_sq_lo", sq_out, 1'b0);
    run = 1'b0;
    t0  = ticks;
    repeat (3) step();
    check("pause2_no_tick", ticks - t0, 0);
    check("pause2_sq_lo", sq_out, 1'b0);
    run = 1'b1;
    wait_tick("pause2_resume", 100, n);
    check("pause2_gap", n + 15, 23);

    // Clear at cnt=15 with FAST pending, then clear exactly on terminal count.
    do_reset();
    wait_tick("clear_first", 100, n);
    repeat (10) step();
    {speedup, slowdown} = 2'b10;
    repeat (5) step();
    clear = 1'b1;
    step();
    check("clear_tick", tick, 1'b0);
    check("clear_mode", mode_q, 2'b10);
    check("clear_sq", sq_out, 1'b1);
    clear = 1'b0;
    wait_tick("clear_after", 100, n);
    check("clear_gap", n, 10);
    repeat (9) step();
    clear = 1'b1;
    step();
    check("clear_tc_tick", tick, 1'b0);
    clear = 1'b0;
    wait_tick("clear_tc_after", 100, n);
    check("clear_tc_gap", n, 10);

    // Reset in the middle of a SLOW period.
    {speedup, slowdown} = 2'b01;
    wait_tick("to_slow", 100, n);
    check("to_slow_gap", n, 10);
    check("to_slow_mode", mode_q, 2'b01);
    repeat (25) step();
    check("mid_slow_sq", sq_out, 1'b0);
    rst_n = 1'b0;
    {speedup, slowdown} = 2'b00;
    step();
    check("mid_rst_tick", tick, 1'b0);
    check("mid_rst_sq", sq_out, 1'b1);
    check("mid_rst_mode", mode_q, 2'b00);
    rst_n = 1'b1;
    wait_tick("post_rst", 100, n);
    check("post_rst_gap", n, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
